// File: rtl/rtc_sched_pkg.sv
// Shared encodings for the RTC command scheduler: command ids, FSM states,
// pending-bit positions and the priority/one-hot helpers built on them.
package rtc_sched_pkg;

  localparam int NCMD = 6;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_INIC  = 3'd1;
  localparam logic [2:0] CMD_STOP  = 3'd2;
  localparam logic [2:0] CMD_HORA  = 3'd3;
  localparam logic [2:0] CMD_FECHA = 3'd4;
  localparam logic [2:0] CMD_TIMER = 3'd5;
  localparam logic [2:0] CMD_LEER  = 3'd6;

  // Pending-bit positions; lower index means higher priority, and cmd id = index + 1.
  localparam int P_INIC  = 0;
  localparam int P_STOP  = 1;
  localparam int P_HORA  = 2;
  localparam int P_FECHA = 3;
  localparam int P_TIMER = 4;
  localparam int P_LEER  = 5;

  localparam logic [NCMD-1:0] PEND_RST = 6'b000001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [2:0] pick_cmd(input logic [NCMD-1:0] pend);
    logic [2:0] c;
    c = CMD_NONE;
    for (int i = NCMD - 1; i >= 0; i--) begin
      if (pend[i]) c = 3'(i + 1);
    end
    return c;
  endfunction

  function automatic logic [NCMD-1:0] cmd_onehot(input logic [2:0] c);
    logic [NCMD-1:0] v;
    v = '0;
    case (c)
      CMD_INIC:  v[P_INIC]  = 1'b1;
      CMD_STOP:  v[P_STOP]  = 1'b1;
      CMD_HORA:  v[P_HORA]  = 1'b1;
      CMD_FECHA: v[P_FECHA] = 1'b1;
      CMD_TIMER: v[P_TIMER] = 1'b1;
      CMD_LEER:  v[P_LEER]  = 1'b1;
      default:   v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rtc_read_tick.sv
// Free-running read-period counter; tick is high for the one cycle the counter
// sits at READ_PERIOD-1 while enabled. Disabling freezes the count in place.
module rtc_read_tick #(
  parameter int unsigned READ_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic auto_en,
  output logic tick
);

  localparam int unsigned CW = (READ_PERIOD > 1) ? $clog2(READ_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(READ_PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == CNT_LAST);
  assign tick    = auto_en & at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (auto_en) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_cmd_sched.sv
// Serialises RTC controller commands: sticky pending bits, fixed priority, one
// registered strobe per command, wait for ready rising edge or watchdog expiry.
module rtc_cmd_sched
  import rtc_sched_pkg::*;
#(
  parameter int unsigned READ_PERIOD = 10_000_000,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_hora,
  input  logic       req_fecha,
  input  logic       req_timer,
  input  logic       req_stop_ring,
  input  logic       req_leer,
  input  logic       auto_en,
  input  logic       ready,
  output logic       inic,
  output logic       stop_ring,
  output logic       esc_hora,
  output logic       esc_fecha,
  output logic       esc_timer,
  output logic       leer,
  output logic       busy,
  output logic       done,
  output logic [2:0] cmd_id,
  output logic       timeout_err
);

  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Leaving WAIT when the count is one short of TIMEOUT-1 makes the error flag
  // visible exactly TIMEOUT cycles after the strobe.
  localparam logic [WW-1:0] WD_EXPIRE = WW'(TIMEOUT - 2);

  state_e          state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic [NCMD-1:0] pend_q, pend_d;
  logic [NCMD-1:0] req_set;
  logic [WW-1:0]   wd_q, wd_d;
  logic            ready_q;
  logic            rdy_edge;
  logic            wd_expire;
  logic            tick;

  logic [NCMD-1:0] strb_q, strb_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2:0]      cmd_q, cmd_d;
  logic            terr_q, terr_d;

  rtc_read_tick #(
    .READ_PERIOD(READ_PERIOD)
  ) u_read_tick (
    .clk    (clk),
    .reset  (reset),
    .auto_en(auto_en),
    .tick   (tick)
  );

  assign rdy_edge  = ready & ~ready_q;
  assign wd_expire = (wd_q == WD_EXPIRE);
  assign req_set   = {req_leer | tick, req_timer, req_fecha, req_hora, req_stop_ring, 1'b0};

  // Set wins over clear, so a request landing during ISSUE survives for a re-issue.
  always_comb begin
    pend_d = pend_q;
    if (state_q == ST_ISSUE) begin
      pend_d = pend_d & ~cmd_onehot(sel_q);
    end
    pend_d = pend_d | req_set;
  end

  always_comb begin
    wd_d = '0;
    if (state_q == ST_WAIT) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          sel_d   = pick_cmd(pend_q);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (rdy_edge) begin
          state_d = ST_DONE;
        end else if (wd_expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every output is a flop.
  always_comb begin
    strb_d = '0;
    busy_d = 1'b0;
    done_d = 1'b0;
    cmd_d  = CMD_NONE;
    terr_d = terr_q;
    case (state_d)
      ST_ISSUE: begin
        strb_d = cmd_onehot(sel_d);
        busy_d = 1'b1;
        cmd_d  = sel_d;
      end
      ST_WAIT: begin
        busy_d = 1'b1;
        cmd_d  = sel_d;
      end
      ST_DONE: begin
        done_d = 1'b1;
        terr_d = 1'b0;
      end
      default: begin
      end
    endcase
    if ((state_q == ST_WAIT) && !rdy_edge && wd_expire) begin
      terr_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sel_q   <= CMD_NONE;
      pend_q  <= PEND_RST;
      wd_q    <= '0;
      ready_q <= 1'b0;
      strb_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cmd_q   <= CMD_NONE;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      wd_q    <= wd_d;
      ready_q <= ready;
      strb_q  <= strb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cmd_q   <= cmd_d;
      terr_q  <= terr_d;
    end
  end

  assign inic        = strb_q[P_INIC];
  assign stop_ring   = strb_q[P_STOP];
  assign esc_hora    = strb_q[P_HORA];
  assign esc_fecha   = strb_q[P_FECHA];
  assign esc_timer   = strb_q[P_TIMER];
  assign leer        = strb_q[P_LEER];
  assign busy        = busy_q;
  assign done        = done_q;
  assign cmd_id      = cmd_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_rtc_cmd_sched.sv
// Directed bench for rtc_cmd_sched with READ_PERIOD=20 and TIMEOUT=50.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_rtc_cmd_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_hora = 1'b0;
  logic       req_fecha = 1'b0;
  logic       req_timer = 1'b0;
  logic       req_stop_ring = 1'b0;
  logic       req_leer = 1'b0;
  logic       auto_en = 1'b0;
  logic       ready = 1'b0;
  logic       inic, stop_ring, esc_hora, esc_fecha, esc_timer, leer;
  logic       busy, done, timeout_err;
  logic [2:0] cmd_id;
  logic [5:0] strb;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  rtc_cmd_sched #(
    .READ_PERIOD(20),
    .TIMEOUT    (50)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_hora     (req_hora),
    .req_fecha    (req_fecha),
    .req_timer    (req_timer),
    .req_stop_ring(req_stop_ring),
    .req_leer     (req_leer),
    .auto_en      (auto_en),
    .ready        (ready),
    .inic         (inic),
    .stop_ring    (stop_ring),
    .esc_hora     (esc_hora),
    .esc_fecha    (esc_fecha),
    .esc_timer    (esc_timer),
    .leer         (leer),
    .busy         (busy),
    .done         (done),
    .cmd_id       (cmd_id),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  assign strb = {leer, esc_timer, esc_fecha, esc_hora, stop_ring, inic};

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ready high for the current cycle only; returns in the following cycle
  task automatic pulse_ready();
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  // id: 0 none within budget, 1..6 command, 7 more than one strobe at once
  task automatic wait_strobe(input int max_cyc, output int id, output int waited);
    bit found;
    id = 0;
    waited = max_cyc;
    found = 1'b0;
    for (int k = 1; k <= max_cyc && !found; k++) begin
      step();
      if (strb != 6'b0) begin
        found = 1'b1;
        waited = k;
        if ($countones(strb) != 1) id = 7;
        else for (int b = 0; b < 6; b++) if (strb[b]) id = b + 1;
      end
    end
  endtask

  task automatic test_reset();
    int id, w;
    reset = 1'b0;
    step();
    step();
    total++;
    if ({strb, busy, done, cmd_id, timeout_err} !== 12'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=0", {strb, busy, done, cmd_id, timeout_err});
    end
    reset = 1'b1;
    step();
    total++;
    if (strb !== 6'b000001 || busy !== 1'b1 || cmd_id !== 3'd1) begin
      bad++;
      $display("FAIL inic_at_r1 strb=%b busy=%b cmd=%0d exp strb=000001 busy=1 cmd=1", strb, busy, cmd_id);
    end
    for (int i = 1; i <= 4; i++) step();
    total++;
    if (busy !== 1'b1 || cmd_id !== 3'd1 || done !== 1'b0 || strb !== 6'b0) begin
      bad++;
      $display("FAIL inic_wait busy=%b cmd=%0d done=%b strb=%b exp 1/1/0/0", busy, cmd_id, done, strb);
    end
    step();
    pulse_ready();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || cmd_id !== 3'd0) begin
      bad++;
      $display("FAIL inic_done done=%b busy=%b cmd=%0d exp 1/0/0", done, busy, cmd_id);
    end
    step();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_one_cycle done=%b exp 0", done);
    end
    wait_strobe(20, id, w);
    total++;
    if (id !== 0) begin
      bad++;
      $display("FAIL inic_once got_cmd=%0d exp none", id);
    end
  endtask

  task automatic test_priority();
    int id, w;
    int exp_id[3] = '{2, 3, 5};
    req_timer = 1'b1;
    req_hora = 1'b1;
    req_stop_ring = 1'b1;
    step();
    req_timer = 1'b0;
    req_hora = 1'b0;
    req_stop_ring = 1'b0;
    for (int n = 0; n < 3; n++) begin
      wait_strobe(10, id, w);
      total++;
      if (id !== exp_id[n] || w !== ((n == 0) ? 1 : 2)) begin
        bad++;
        $display("FAIL prio_order_%0d got_cmd=%0d after=%0d exp_cmd=%0d after=%0d",
                 n, id, w, exp_id[n], (n == 0) ? 1 : 2);
      end
      total++;
      if (cmd_id !== 3'(exp_id[n])) begin
        bad++;
        $display("FAIL prio_cmd_id_%0d got=%0d exp=%0d", n, cmd_id, exp_id[n]);
      end
      step();
      pulse_ready();
      total++;
      if (done !== 1'b1) begin
        bad++;
        $display("FAIL prio_done_%0d done=%b exp 1", n, done);
      end
    end
    wait_strobe(15, id, w);
    total++;
    if (id !== 0) begin
      bad++;
      $display("FAIL prio_extra got_cmd=%0d exp none", id);
    end
  endtask

  task automatic test_back_to_back();
    int id, w;
    req_hora = 1'b1;
    step();
    req_hora = 1'b0;
    wait_strobe(10, id, w);
    total++;
    if (id !== 3 || w !== 1) begin
      bad++;
      $display("FAIL hora_first got_cmd=%0d after=%0d exp 3 after 1", id, w);
    end
    step();
    step();
    req_hora = 1'b1;
    step();
    req_hora = 1'b0;
    step();
    pulse_ready();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL hora_first_done done=%b exp 1", done);
    end
    wait_strobe(10, id, w);
    total++;
    if (id !== 3 || w !== 2) begin
      bad++;
      $display("FAIL hora_reissue got_cmd=%0d after=%0d exp 3 after 2", id, w);
    end
    step();
    pulse_ready();
    wait_strobe(30, id, w);
    total++;
    if (id !== 0) begin
      bad++;
      $display("FAIL hora_third got_cmd=%0d exp none", id);
    end
  endtask

  task automatic test_mid_reset();
    int id, w;
    req_fecha = 1'b1;
    step();
    req_fecha = 1'b0;
    wait_strobe(10, id, w);
    total++;
    if (id !== 4) begin
      bad++;
      $display("FAIL fecha_strobe got_cmd=%0d exp 4", id);
    end
    step();
    req_timer = 1'b1;
    req_leer = 1'b1;
    step();
    req_timer = 1'b0;
    req_leer = 1'b0;
    step();
    total++;
    if (busy !== 1'b1 || cmd_id !== 3'd4) begin
      bad++;
      $display("FAIL fecha_in_wait busy=%b cmd=%0d exp 1/4", busy, cmd_id);
    end
    reset = 1'b0;
    step();
    total++;
    if ({strb, busy, done, cmd_id, timeout_err} !== 12'b0) begin
      bad++;
      $display("FAIL abort_outputs got=%b exp=0", {strb, busy, done, cmd_id, timeout_err});
    end
    reset = 1'b1;
    step();
    total++;
    if (strb !== 6'b000001) begin
      bad++;
      $display("FAIL abort_inic strb=%b exp 000001", strb);
    end
    step();
    pulse_ready();
    wait_strobe(30, id, w);
    total++;
    if (id !== 0) begin
      bad++;
      $display("FAIL abort_pending_lost got_cmd=%0d exp none", id);
    end
  endtask

  task automatic test_timeout_tick();
    int id, w;
    auto_en = 1'b1;
    wait_strobe(40, id, w);
    total++;
    if (id !== 6 || w !== 21) begin
      bad++;
      $display("FAIL tick_leer got_cmd=%0d after=%0d exp 6 after 21", id, w);
    end
    for (int i = 1; i <= 49; i++) step();
    total++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_timeout terr=%b busy=%b exp 0/1", timeout_err, busy);
    end
    step();
    total++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || cmd_id !== 3'd0) begin
      bad++;
      $display("FAIL timeout_at_50 terr=%b busy=%b cmd=%0d exp 1/0/0", timeout_err, busy, cmd_id);
    end
    wait_strobe(3, id, w);
    total++;
    if (id !== 6 || w > 2) begin
      bad++;
      $display("FAIL leer_after_timeout got_cmd=%0d after=%0d exp 6 within 2", id, w);
    end
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL terr_sticky terr=%b exp 1", timeout_err);
    end
    step();
    pulse_ready();
    auto_en = 1'b0;
    total++;
    if (done !== 1'b1 || timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL terr_clear done=%b terr=%b exp 1/0", done, timeout_err);
    end
  endtask

  task automatic test_ready_stuck();
    int id, w;
    int done_start;
    ready = 1'b1;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    done_start = done_cnt;
    step();
    total++;
    if (strb !== 6'b000001) begin
      bad++;
      $display("FAIL stuck_inic strb=%b exp 000001", strb);
    end
    for (int i = 1; i <= 50; i++) step();
    total++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stuck_inic_timeout terr=%b busy=%b exp 1/0", timeout_err, busy);
    end
    req_hora = 1'b1;
    step();
    req_hora = 1'b0;
    wait_strobe(5, id, w);
    total++;
    if (id !== 3) begin
      bad++;
      $display("FAIL stuck_hora got_cmd=%0d exp 3", id);
    end
    for (int i = 1; i <= 50; i++) step();
    total++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || cmd_id !== 3'd0) begin
      bad++;
      $display("FAIL stuck_hora_timeout terr=%b busy=%b cmd=%0d exp 1/0/0", timeout_err, busy, cmd_id);
    end
    total++;
    if (done_cnt - done_start !== 0) begin
      bad++;
      $display("FAIL stuck_no_done done_pulses=%0d exp 0", done_cnt - done_start);
    end
    ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_back_to_back();
    test_mid_reset();
    test_timeout_tick();
    test_ready_stuck();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
